// File: rtl/pipelined_carry_bypass_adder_if.sv
// Operand/result bundle for the pipelined carry-bypass adder.
// master: in_valid,a,b,cin,sub,out_ready -> ; slave: in_ready,out_valid,sum,cout,overflow ->
// With CBA_FLAGS_EN defined, zero/negative flags are added to the result side.
interface pipelined_carry_bypass_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
`ifdef CBA_FLAGS_EN
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow,
    input  zero, negative
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow,
    output zero, negative
  );
`else
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
`endif
endinterface

// File: rtl/pipelined_carry_bypass_adder.sv
// Pipelined carry-bypass adder/subtractor, STAGES register ranks, valid/ready flow.
// Ports: clk, rst_n (async active-low), bus (slave modport: operands in, result out).
// Macro CBA_FLAGS_EN adds registered zero/negative result flags.
module pipelined_carry_bypass_adder #(
  parameter int WIDTH      = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  pipelined_carry_bypass_adder_if.slave bus
);
  localparam int NB  = (WIDTH + BLOCK_SIZE - 1) / BLOCK_SIZE;
  localparam int BPS = (NB + STAGES - 1) / STAGES;

  logic adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO  = k * BPS * BLOCK_SIZE;
    localparam int TOP = LO + BPS * BLOCK_SIZE;
    localparam int HI  = (TOP > WIDTH) ? WIDTH : TOP;

    logic             v_in, c_in, m_in;
    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             v_q, c_q, m_q;
    logic             c_d, m_d;
    logic [WIDTH-1:0] s_q, s_d;

    if (k == 0) begin : g_src
      // b is pre-inverted for subtract; carry-in forced to 1
      assign v_in = bus.in_valid;
      assign a_in = bus.a;
      assign b_in = bus.b ^ {WIDTH{bus.sub}};
      assign c_in = bus.sub | bus.cin;
      assign s_in = '0;
      assign m_in = 1'b0;
    end else begin : g_src
      assign v_in = g_st[k-1].v_q;
      assign a_in = g_st[k-1].g_ab.a_q;
      assign b_in = g_st[k-1].g_ab.b_q;
      assign c_in = g_st[k-1].c_q;
      assign s_in = g_st[k-1].s_q;
      assign m_in = g_st[k-1].m_q;
    end

    // Ripple inside each block; block carry-out skips
    // the ripple when every bit propagates.
    always_comb begin
      logic rc, p, x;
      s_d = s_in;
      c_d = c_in;
      m_d = m_in;
      rc  = c_in;
      p   = 1'b1;
      x   = 1'b0;
      for (int i = LO; i < HI; i++) begin
        if (i % BLOCK_SIZE == 0) begin
          rc = c_d;
          p  = 1'b1;
        end
        x      = a_in[i] ^ b_in[i];
        s_d[i] = x ^ rc;
        if (i == WIDTH - 1) m_d = rc;
        rc = (a_in[i] & b_in[i]) | (x & rc);
        p  = p & x;
        if ((i % BLOCK_SIZE == BLOCK_SIZE - 1) || (i == HI - 1)) begin
          if (!p) c_d = rc;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        m_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= c_d;
          m_q <= m_d;
          s_q <= s_d;
        end
      end
    end

    // Unsummed operand slices only needed by later stages
    if (k < STAGES - 1) begin : g_ab
      logic [WIDTH-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && v_in) begin
          a_q <= a_in;
          b_q <= b_in;
        end
      end
    end
  end

  assign adv          = ~g_st[STAGES-1].v_q | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = g_st[STAGES-1].v_q;
  assign bus.sum      = g_st[STAGES-1].s_q;
  assign bus.cout     = g_st[STAGES-1].c_q;
  assign bus.overflow = g_st[STAGES-1].m_q ^ g_st[STAGES-1].c_q;

`ifdef CBA_FLAGS_EN
  logic zero_q, neg_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (adv && g_st[STAGES-1].v_in) begin
      zero_q <= ~|g_st[STAGES-1].s_d;
      neg_q  <= g_st[STAGES-1].s_d[WIDTH-1];
    end
  end
  assign bus.zero     = zero_q;
  assign bus.negative = neg_q;
`endif
endmodule

// File: tb/tb_pipelined_carry_bypass_adder.sv
// Randomized bench for pipelined_carry_bypass_adder with a queue-based reference model.
// Main DUT 32/4/2; second DUT 10/4/3 covers the partial-block configuration.
module tb_pipelined_carry_bypass_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_carry_bypass_adder_if #(.WIDTH(32)) bi();
  pipelined_carry_bypass_adder_if #(.WIDTH(10)) bj();

  pipelined_carry_bypass_adder #(
    .WIDTH(32), .BLOCK_SIZE(4), .STAGES(2)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bi));

  pipelined_carry_bypass_adder #(
    .WIDTH(10), .BLOCK_SIZE(4), .STAGES(3)
  ) dut6 (.clk(clk), .rst_n(rst_n), .bus(bj));

  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        v;
  } res_t;

  res_t q[$];
  int total = 0;
  int bad = 0;
  int pops = 0;
  int run = 0;
  int maxrun = 0;

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // Plain arithmetic reference; overflow from operand/result signs
  function automatic res_t model(logic [31:0] a, logic [31:0] b,
                                 logic cin, logic sub);
    res_t r;
    logic [32:0] t;
    logic [31:0] bb;
    bb = sub ? ~b : b;
    t = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
    r.s = t[31:0];
    r.c = t[32];
    r.v = (a[31] == bb[31]) && (t[31] != a[31]);
    return r;
  endfunction

  function automatic logic [11:0] model10(logic [9:0] a, logic [9:0] b,
                                          logic cin, logic sub);
    int unsigned bb, t;
    logic ov;
    bb = sub ? (~{22'd0, b} & 32'h3FF) : {22'd0, b};
    t = {22'd0, a} + bb + (sub ? 1 : {31'd0, cin});
    ov = (a[9] == bb[9]) && (t[9] != a[9]);
    return {ov, t[10], t[9:0]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Single compare process for the main DUT
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      run = 0;
    end else begin
      chk("in_ready", bi.in_ready, !bi.out_valid || bi.out_ready);
      if (bi.out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", bi.out_valid, 0);
        end else begin
          chk("sum", bi.sum, q[0].s);
          chk("cout", bi.cout, q[0].c);
          chk("overflow", bi.overflow, q[0].v);
`ifdef CBA_FLAGS_EN
          chk("zero", bi.zero, q[0].s == 0);
          chk("negative", bi.negative, q[0].s[31]);
`endif
        end
      end
      if (bi.out_valid && bi.out_ready && q.size() > 0) begin
        void'(q.pop_front());
        pops++;
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (bi.in_valid && bi.in_ready)
        q.push_back(model(bi.a, bi.b, bi.cin, bi.sub));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [31:0] a, logic [31:0] b, logic cin, logic sub);
    bi.in_valid = 1'b1;
    bi.a = a;
    bi.b = b;
    bi.cin = cin;
    bi.sub = sub;
  endtask

  logic [31:0] hs;
  int p0;
  logic [11:0] e10;

  initial begin
    bi.in_valid = 0; bi.a = 0; bi.b = 0; bi.cin = 0; bi.sub = 0;
    bi.out_ready = 1;
    bj.in_valid = 0; bj.a = 0; bj.b = 0; bj.cin = 0; bj.sub = 0;
    bj.out_ready = 1;
    #1;
    chk("rst_out_valid", bi.out_valid, 0);
    chk("rst_sum", bi.sum, 0);
    chk("rst_cout", bi.cout, 0);
    chk("rst_overflow", bi.overflow, 0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", bi.in_ready, 1);

    // full bypass chain add
    drive(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
    step();
    bi.in_valid = 0;
    chk("t1_lat", bi.out_valid, 0);
    step();
    chk("t1_valid", bi.out_valid, 1);
    chk("t1_sum", bi.sum, 32'h0);
    chk("t1_cout", bi.cout, 1);
    chk("t1_ov", bi.overflow, 0);

    // subtract with signed overflow
    drive(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    step();
    bi.in_valid = 0;
    step();
    chk("t2_valid", bi.out_valid, 1);
    chk("t2_sum", bi.sum, 32'h7FFF_FFFF);
    chk("t2_cout", bi.cout, 1);
    chk("t2_ov", bi.overflow, 1);
    step(); step();

    // 8 back-to-back ops
    maxrun = 0;
    for (int i = 0; i < 8; i++) begin
      drive(pick(), pick(), 1'($urandom), 1'($urandom));
      step();
    end
    bi.in_valid = 0;
    repeat (4) step();
    chk("stream_run", maxrun, 8);

    // stall with 2 in flight
    p0 = pops;
    drive(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0);
    step();
    drive(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b1);
    step();
    bi.in_valid = 0;
    bi.out_ready = 0;
    hs = bi.sum;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_in_ready", bi.in_ready, 0);
      chk("stall_valid", bi.out_valid, 1);
      chk("stall_sum", bi.sum, hs);
    end
    bi.out_ready = 1;
    repeat (4) step();
    chk("stall_pops", pops - p0, 2);
    chk("stall_drain", q.size(), 0);

    // reset with two valid stages
    drive(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    step();
    drive(32'h0000_0F00, 32'h0000_0001, 1'b0, 1'b0);
    step();
    bi.in_valid = 0;
    bi.out_ready = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", bi.out_valid, 0);
    chk("rst_mid_sum", bi.sum, 0);
    step(); step();
    rst_n = 1'b1;
    bi.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_mid_quiet", bi.out_valid, 0);
    end

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) drive(pick(), pick(), 1'($urandom), 1'($urandom));
      else bi.in_valid = 0;
      bi.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    bi.in_valid = 0;
    bi.out_ready = 1;
    for (int i = 0; i < 20 && q.size() != 0; i++) step();
    chk("rand_drain", q.size(), 0);

    // 10-bit, 3-stage, partial last block
    bj.in_valid = 1; bj.a = 10'h3FF; bj.b = 10'h001; bj.cin = 1; bj.sub = 0;
    step();
    bj.in_valid = 0;
    chk("t6_lat1", bj.out_valid, 0);
    step();
    chk("t6_lat2", bj.out_valid, 0);
    step();
    chk("t6_valid", bj.out_valid, 1);
    chk("t6_sum", bj.sum, 10'h001);
    chk("t6_cout", bj.cout, 1);
    chk("t6_ov", bj.overflow, 0);
    step();
    for (int n = 0; n < 24; n++) begin
      bj.in_valid = 1;
      bj.a = 10'($urandom);
      bj.b = 10'($urandom);
      bj.cin = 1'($urandom);
      bj.sub = 1'($urandom);
      e10 = model10(bj.a, bj.b, bj.cin, bj.sub);
      step();
      bj.in_valid = 0;
      for (int i = 0; i < 6 && !bj.out_valid; i++) step();
      chk("w10_valid", bj.out_valid, 1);
      chk("w10_res", {bj.overflow, bj.cout, bj.sum}, e10);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
